// File: rtl/pipelined_decoder_pkg.sv
// Shared types for the pipelined decoder: the operating-mode enum built
// from the encodings in decoder_defs.vh.
`ifndef DECODER_DEFS_VH
`include "decoder_defs.vh"
`endif

package pipelined_decoder_pkg;

    typedef enum logic [1:0] {
        M_DIRECT = `MODE_DIRECT,
        M_SCAN   = `MODE_SCAN,
        M_THERM  = `MODE_THERM,
        M_HOLD   = `MODE_HOLD
    } mode_e;

endpackage

// File: rtl/decoder_defs.vh
// Mode encodings for pipelined_decoder, shared by the RTL and the bench.
`ifndef DECODER_DEFS_VH
`define DECODER_DEFS_VH

`define MODE_DIRECT 2'b00
`define MODE_SCAN   2'b01
`define MODE_THERM  2'b10
`define MODE_HOLD   2'b11

`endif

// File: rtl/pipelined_decoder_onehot_decode.sv
// Combinational binary-to-one-hot decoder; one instance serves both the
// direct path (address A) and the scan path (counter).
module onehot_decode #(
    parameter int N = 2
) (
    input  logic [N-1:0]      a_i,
    output logic [2**N-1:0]   y_o
);

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        y_o      = '0;
        y_o[a_i] = 1'b1;
    end

endmodule

// File: rtl/pipelined_decoder.sv
// Registered one-hot / thermometer decoder with a free-running scan
// counter; every output changes one clock after its inputs are sampled.
module pipelined_decoder
    import pipelined_decoder_pkg::*;
#(
    parameter int N = 2,               // address width, legal range 1..6
    localparam int W = 2**N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           EN,
    input  logic [1:0]     MODE,
    input  logic [N-1:0]   A,
    input  logic           VALID_IN,
    output logic [W-1:0]   D,
    output logic           VALID_OUT,
    output logic [N-1:0]   CNT,
    output logic           WRAP
);

    mode_e          mode;
    logic [N-1:0]   dec_sel;
    logic [W-1:0]   onehot;
    logic [W-1:0]   therm;

    logic [W-1:0]   d_q,     d_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   cnt_q,   cnt_d;
    logic           wrap_q,  wrap_d;

    assign mode = mode_e'(MODE);

    // Scan decodes the counter, every other mode decodes the address.
    assign dec_sel = (mode == M_SCAN) ? cnt_q : A;

    onehot_decode #(.N(N)) u_onehot (
        .a_i (dec_sel),
        .y_o (onehot)
    );

    always_comb begin
        for (int i = 0; i < W; i++) begin
            therm[i] = (N'(i) <= A);
        end
    end

    // Default: outputs hold, pulses drop; only an enabled active mode overrides.
    always_comb begin
        d_d     = d_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (EN) begin
            unique case (mode)
                M_DIRECT: begin
                    if (VALID_IN) begin
                        d_d     = onehot;
                        valid_d = 1'b1;
                    end
                end
                M_THERM: begin
                    if (VALID_IN) begin
                        d_d     = therm;
                        valid_d = 1'b1;
                    end
                end
                M_SCAN: begin
                    d_d     = onehot;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;   // N-bit add wraps W-1 -> 0
                    wrap_d  = &cnt_q;
                end
                M_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign D         = d_q;
    assign VALID_OUT = valid_q;
    assign CNT       = cnt_q;
    assign WRAP      = wrap_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Directed self-checking bench for pipelined_decoder (N=2 main instance,
// N=3 instance for width generalisation).
`ifndef DECODER_DEFS_VH
`include "decoder_defs.vh"
`endif

module tb_pipelined_decoder;

    logic       clk;
    logic       rst;

    logic       en;
    logic [1:0] mode;
    logic [1:0] a;
    logic       valid_in;
    logic [3:0] d;
    logic       valid_out;
    logic [1:0] cnt;
    logic       wrap;

    logic       en3;
    logic [1:0] mode3;
    logic [2:0] a3;
    logic       valid_in3;
    logic [7:0] d3;
    logic       valid_out3;
    logic [2:0] cnt3;
    logic       wrap3;

    int checks = 0;
    int errors = 0;

    pipelined_decoder #(.N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (en),
        .MODE      (mode),
        .A         (a),
        .VALID_IN  (valid_in),
        .D         (d),
        .VALID_OUT (valid_out),
        .CNT       (cnt),
        .WRAP      (wrap)
    );

    pipelined_decoder #(.N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .EN        (en3),
        .MODE      (mode3),
        .A         (a3),
        .VALID_IN  (valid_in3),
        .D         (d3),
        .VALID_OUT (valid_out3),
        .CNT       (cnt3),
        .WRAP      (wrap3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp_d, input logic exp_v,
                             input logic [1:0] exp_cnt, input logic exp_wrap);
        check({tag, ".D"},     {28'd0, d},         {28'd0, exp_d});
        check({tag, ".VALID"}, {31'd0, valid_out}, {31'd0, exp_v});
        check({tag, ".CNT"},   {30'd0, cnt},       {30'd0, exp_cnt});
        check({tag, ".WRAP"},  {31'd0, wrap},      {31'd0, exp_wrap});
    endtask

    logic [3:0] scan_d    [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] scan_cnt  [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic       scan_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] th_a      [3] = '{2'b10, 2'b00, 2'b11};
    logic [3:0] th_d      [3] = '{4'b0111, 4'b0001, 4'b1111};

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = `MODE_DIRECT;
        a         = '0;
        valid_in  = 1'b0;
        en3       = 1'b0;
        mode3     = `MODE_DIRECT;
        a3        = '0;
        valid_in3 = 1'b0;

        #2;
        check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        check("reset.D3", {24'd0, d3}, 32'h0);
        #10 rst = 1'b0;

        // Direct decode on consecutive edges.
        en       = 1'b1;
        valid_in = 1'b1;
        mode     = `MODE_DIRECT;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            tick();
            check_out($sformatf("direct%0d", i), 4'(1 << i), 1'b1, 2'd0, 1'b0);
        end

        // VALID_IN low holds D and drops VALID_OUT.
        valid_in = 1'b0;
        tick();
        check_out("novalid", 4'b1000, 1'b0, 2'd0, 1'b0);

        // Thermometer decode.
        valid_in = 1'b1;
        mode     = `MODE_THERM;
        for (int i = 0; i < 3; i++) begin
            a = th_a[i];
            tick();
            check_out($sformatf("therm%0d", i), th_d[i], 1'b1, 2'd0, 1'b0);
        end

        // Hold mode freezes D and CNT.
        mode = `MODE_HOLD;
        tick();
        check_out("hold", 4'b1111, 1'b0, 2'd0, 1'b0);

        // Asynchronous reset pulse between edges, then scan from reset.
        #2 rst = 1'b1;
        #1;
        check_out("rst_pulse", 4'b0000, 1'b0, 2'd0, 1'b0);
        #1 rst = 1'b0;
        mode     = `MODE_SCAN;
        valid_in = 1'b0;
        a        = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out($sformatf("scan%0d", i), scan_d[i], 1'b1, scan_cnt[i], scan_wrap[i]);
        end

        // Enable freeze after D=0100.
        tick();
        check_out("scan_pre_freeze", 4'b0100, 1'b1, 2'd3, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("freeze%0d", i), 4'b0100, 1'b0, 2'd3, 1'b0);
        end
        en = 1'b1;
        tick();
        check_out("unfreeze", 4'b1000, 1'b1, 2'd0, 1'b1);
        tick();
        check_out("scan_resume", 4'b0001, 1'b1, 2'd1, 1'b0);

        // Mode changes take effect on the next edge; CNT is retained.
        mode     = `MODE_DIRECT;
        valid_in = 1'b1;
        a        = 2'b10;
        tick();
        check_out("leave_scan", 4'b0100, 1'b1, 2'd1, 1'b0);
        mode = `MODE_SCAN;
        tick();
        check_out("reenter_scan", 4'b0010, 1'b1, 2'd2, 1'b0);

        // Reset mid-scan while CNT=10.
        #2 rst = 1'b1;
        #1;
        check_out("rst_midscan", 4'b0000, 1'b0, 2'd0, 1'b0);
        #1 rst = 1'b0;
        tick();
        check_out("scan_after_rst", 4'b0001, 1'b1, 2'd1, 1'b0);

        // Width generalisation on the N=3 instance.
        en3       = 1'b1;
        valid_in3 = 1'b1;
        mode3     = `MODE_DIRECT;
        a3        = 3'b101;
        tick();
        check("n3_direct.D", {24'd0, d3}, 32'h20);
        check("n3_direct.VALID", {31'd0, valid_out3}, 32'd1);
        mode3 = `MODE_THERM;
        tick();
        check("n3_therm.D", {24'd0, d3}, 32'h3F);
        a3 = 3'b111;
        tick();
        check("n3_therm_max.D", {24'd0, d3}, 32'hFF);
        check("n3.CNT", {29'd0, cnt3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
